// File: rtl/ca_nbit_stepper.sv
// ca_nbit_stepper: hybrid rule-90/rule-150 cellular-automaton pattern source.
// A seed can be loaded while idle. The CA is then stepped either for a fixed
// burst of steps or free-running, and only advances while step_en is high.
module ca_nbit_stepper #(
   parameter int                WIDTH        = 8,
   parameter logic [WIDTH-1:0]  RULE_MASK    = 8'b0010_1010,
   parameter int                BOUNDARY     = 0,
   parameter logic [WIDTH-1:0]  DEFAULT_SEED = 8'h01,
   parameter int                CNT_W        = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              seed_valid,
   output logic              seed_ready,
   input  logic [WIDTH-1:0]  seed,
   input  logic              start,
   input  logic [CNT_W-1:0]  step_count,
   input  logic              step_en,
   input  logic              stop,
   output logic [WIDTH-1:0]  ca_out,
   output logic              out_valid,
   output logic              busy,
   output logic              done,
   output logic              seed_err,
   output logic              zero_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_reg, state_next;
   logic [WIDTH-1:0]    ca_reg, ca_next;
   logic [CNT_W-1:0]    count_reg, count_next;
   logic                free_reg, free_next;
   logic                out_valid_reg, out_valid_next;
   logic                done_reg, done_next;
   logic                seed_err_reg, seed_err_next;

   // The state is padded with one neighbour cell at each end. These cells
   // read 0 (null boundary) or the opposite end cell (periodic boundary).
   logic [WIDTH+1:0]    padded;
   logic [WIDTH-1:0]    step_value;

   assign padded = {((BOUNDARY != 0) ? ca_reg[0] : 1'b0),
                    ca_reg,
                    ((BOUNDARY != 0) ? ca_reg[WIDTH-1] : 1'b0)};

   // Each cell is its left and right neighbours XORed. Rule-150 cells also XOR in their own value.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_cell
         assign step_value[gi] = padded[gi+2] ^ padded[gi] ^ (RULE_MASK[gi] & padded[gi+1]);
      end
   endgenerate

   // Next-state and datapath decisions. Every target gets its default first.
   always_comb begin
      state_next     = state_reg;
      ca_next        = ca_reg;
      count_next     = count_reg;
      free_next      = free_reg;
      out_valid_next = 1'b0;
      done_next      = 1'b0;
      seed_err_next  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (seed_valid) begin
               // A seed load takes precedence over start. A zero seed is
               // rejected because the all-zero state never leaves itself.
               if (seed != '0) begin
                  ca_next = seed;
               end else begin
                  seed_err_next = 1'b1;
               end
            end else if (start) begin
               count_next = step_count;
               free_next  = (step_count == '0);
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_next = ST_IDLE;
            end else if (step_en) begin
               ca_next        = step_value;
               out_valid_next = 1'b1;
               if (!free_reg) begin
                  count_next = count_reg - CNT_W'(1);
                  if (count_reg == CNT_W'(1)) begin
                     state_next = ST_DONE;
                  end
               end
            end
         end
         ST_DONE: begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State register and registered outputs, with a synchronous reset to the default seed.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         ca_reg        <= DEFAULT_SEED;
         count_reg     <= '0;
         free_reg      <= 1'b0;
         out_valid_reg <= 1'b0;
         done_reg      <= 1'b0;
         seed_err_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         ca_reg        <= ca_next;
         count_reg     <= count_next;
         free_reg      <= free_next;
         out_valid_reg <= out_valid_next;
         done_reg      <= done_next;
         seed_err_reg  <= seed_err_next;
      end
   end

   assign ca_out     = ca_reg;
   assign out_valid  = out_valid_reg;
   assign done       = done_reg;
   assign seed_err   = seed_err_reg;
   assign seed_ready = (state_reg == ST_IDLE);
   assign busy       = (state_reg == ST_RUN);
   assign zero_state = (ca_reg == '0);

endmodule
